// File: rtl/ascon_pack.sv
// ascon_pack: shared ASCON state type, FSM states and S-box tables.
// The inverse table exists only when ASCON_SBOX_INV_EN is defined.
package ascon_pack;
  localparam int ASCON_COLS = 64;
  typedef logic [4:0][ASCON_COLS-1:0] type_state;
  typedef enum logic {IDLE, BUSY} ps_fsm_e;
  localparam logic [4:0] SBOX_FWD [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h17, 5'h0a, 5'h0f, 5'h16
  };
`ifdef ASCON_SBOX_INV_EN
  localparam logic [4:0] SBOX_INV [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1f, 5'h1c,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };
`endif
endpackage

// File: rtl/ps_slice.sv
// ps_slice: combinational S-box layer over a LANES-column slice.
// Inverse select (inv_i) exists only with ASCON_SBOX_INV_EN.
module ps_slice
  import ascon_pack::*;
#(
  parameter int LANES = 8
) (
`ifdef ASCON_SBOX_INV_EN
  input  logic                   inv_i,
`endif
  input  logic [4:0][LANES-1:0] slice_i,
  output logic [4:0][LANES-1:0] slice_o
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [4:0] col, fwd, res;
    // word 0 supplies the column MSB
    assign col = {slice_i[0][i], slice_i[1][i], slice_i[2][i], slice_i[3][i], slice_i[4][i]};
    sbox u_sbox (.x_i(col), .y_o(fwd));
`ifdef ASCON_SBOX_INV_EN
    assign res = inv_i ? SBOX_INV[col] : fwd;
`else
    assign res = fwd;
`endif
    for (genvar j = 0; j < 5; j++) begin : g_word
      assign slice_o[j][i] = res[4-j];
    end
  end
endmodule

// File: rtl/sbox.sv
// sbox: forward 5-bit ASCON S-box as a table lookup.
module sbox
  import ascon_pack::*;
(
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);
  assign y_o = SBOX_FWD[x_i];
endmodule

// File: rtl/permutation_substitution_seq.sv
// permutation_substitution_seq: ASCON p_S substituting LANES columns per cycle.
// Define ASCON_SBOX_INV_EN to add the inv_i port and inverse S-box.
module permutation_substitution_seq
  import ascon_pack::*;
#(
  parameter int LANES = 8
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
`ifdef ASCON_SBOX_INV_EN
  input  logic      inv_i,
`endif
  input  type_state state_i,
  output logic      ready_o,
  output logic      valid_o,
  output type_state state_o
);
  localparam int N = ASCON_COLS / LANES;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int IW = $clog2(ASCON_COLS);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (LANES < 1 || LANES > ASCON_COLS || ASCON_COLS % LANES != 0) begin : g_bad_lanes
    $error("LANES must divide 64");
  end
  ps_fsm_e fsm_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] base;
  logic valid_q;
  type_state work_q, work_d;
  logic [4:0][LANES-1:0] sl_in, sl_out;
`ifdef ASCON_SBOX_INV_EN
  logic inv_q;
`endif
  assign base = IW'(cnt_q * LANES);
  always_comb begin
    work_d = work_q;
    for (int w = 0; w < 5; w++) begin
      sl_in[w] = work_q[w][base +: LANES];
      work_d[w][base +: LANES] = sl_out[w];
    end
  end
  ps_slice #(.LANES(LANES)) u_slice (
`ifdef ASCON_SBOX_INV_EN
    .inv_i  (inv_q),
`endif
    .slice_i(sl_in),
    .slice_o(sl_out)
  );
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      valid_q <= 1'b0;
`ifdef ASCON_SBOX_INV_EN
      inv_q   <= 1'b0;
`endif
    end else if (fsm_q == IDLE) begin
      valid_q <= 1'b0;
      if (start_i) begin
        work_q <= state_i;
        cnt_q  <= '0;
        fsm_q  <= BUSY;
`ifdef ASCON_SBOX_INV_EN
        inv_q  <= inv_i;
`endif
      end
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
      valid_q <= cnt_q == LAST;
      fsm_q   <= cnt_q == LAST ? IDLE : BUSY;
    end
  end
  assign ready_o = fsm_q == IDLE;
  assign valid_o = valid_q;
  assign state_o = work_q;
endmodule

// File: tb/tb_permutation_substitution_seq.sv
// tb_permutation_substitution_seq: directed checks of p_S across every legal LANES.
// Define ASCON_SBOX_INV_EN to also exercise the inverse S-box.
module tb_permutation_substitution_seq;
  import ascon_pack::*;
  localparam int NI = 7;
  logic clk = 1'b0;
  logic rst, start;
`ifdef ASCON_SBOX_INV_EN
  logic inv;
`endif
  type_state sin;
  logic rdy [NI];
  logic vld [NI];
  type_state so [NI];
  int vectors = 0;
  int errors = 0;
  logic [4:0] sbf [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h17, 5'h0a, 5'h0f, 5'h16
  };
  logic [4:0] sbi [32];
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    permutation_substitution_seq #(.LANES(1 << g)) dut (
      .clock_i(clk),
      .reset_i(rst),
      .start_i(start),
`ifdef ASCON_SBOX_INV_EN
      .inv_i  (inv),
`endif
      .state_i(sin),
      .ready_o(rdy[g]),
      .valid_o(vld[g]),
      .state_o(so[g])
    );
  end
  function automatic type_state model(input type_state s, input bit iv);
    type_state r;
    logic [4:0] x, y;
    r = '0;
    for (int c = 0; c < 64; c++) begin
      x = {s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]};
      y = iv ? sbi[x] : sbf[x];
      for (int w = 0; w < 5; w++) r[w][c] = y[4-w];
    end
    return r;
  endfunction
  function automatic type_state rnd_state();
    type_state r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom(), $urandom()};
    return r;
  endfunction
  function automatic int n_of(input int k);
    return 64 >> k;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // one accepted start, then watch every instance for its valid pulse
  task automatic run_op(input type_state s, output int lat [NI], output type_state res [NI]);
    int e;
    for (int k = 0; k < NI; k++) begin
      lat[k] = 0;
      res[k] = '0;
    end
    sin = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    sin = ~s;
    e = 1;
    while (e < 70) begin
      tick();
      e++;
      for (int k = 0; k < NI; k++)
        if (vld[k] && lat[k] == 0) begin
          lat[k] = e;
          res[k] = so[k];
        end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (rdy[k] !== 1'b1 || vld[k] !== 1'b0 || so[k] !== '0) begin
        errors++;
        $display("FAIL reset L=%0d got rdy=%b vld=%b so=%h want rdy=1 vld=0 so=0", 1 << k, rdy[k], vld[k], so[k]);
      end
    end
  endtask
  task automatic test_zero();
    int lat [NI];
    type_state res [NI];
    type_state e;
    e = '0;
    e[2] = '1;
    run_op('0, lat, res);
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (lat[k] !== n_of(k) + 1) begin
        errors++;
        $display("FAIL zero_latency L=%0d got %0d want %0d", 1 << k, lat[k], n_of(k) + 1);
      end
      vectors++;
      if (res[k] !== e) begin
        errors++;
        $display("FAIL zero_result L=%0d got %h want %h", 1 << k, res[k], e);
      end
    end
  endtask
  task automatic test_ones();
    int lat [NI];
    type_state res [NI];
    type_state e;
    e = '0;
    e[0] = '1;
    e[2] = '1;
    e[3] = '1;
    run_op('1, lat, res);
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (lat[k] !== n_of(k) + 1) begin
        errors++;
        $display("FAIL ones_latency L=%0d got %0d want %0d", 1 << k, lat[k], n_of(k) + 1);
      end
      vectors++;
      if (res[k] !== e) begin
        errors++;
        $display("FAIL ones_result L=%0d got %h want %h", 1 << k, res[k], e);
      end
    end
  endtask
  task automatic test_random();
    int lat [NI];
    type_state res [NI];
    type_state s, e;
    for (int t = 0; t < 3; t++) begin
      s = rnd_state();
      e = model(s, 1'b0);
      run_op(s, lat, res);
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (lat[k] !== n_of(k) + 1 || res[k] !== e) begin
          errors++;
          $display("FAIL random L=%0d got lat=%0d %h want lat=%0d %h", 1 << k, lat[k], res[k], n_of(k) + 1, e);
        end
        vectors++;
        if (so[k] !== e || vld[k] !== 1'b0) begin
          errors++;
          $display("FAIL hold L=%0d got vld=%b %h want vld=0 %h", 1 << k, vld[k], so[k], e);
        end
      end
    end
  endtask
  task automatic test_busy_start();
    int nv [NI];
    type_state s1, e;
    s1 = rnd_state();
    e = model(s1, 1'b0);
    for (int k = 0; k < NI; k++) nv[k] = 0;
    sin = s1;
    start = 1'b1;
    tick();
    sin = rnd_state();
    tick();
    start = 1'b0;
    for (int k = 0; k < NI; k++) if (vld[k]) nv[k]++;
    for (int c = 0; c < 80; c++) begin
      tick();
      for (int k = 0; k < NI; k++) if (vld[k]) nv[k]++;
    end
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (nv[k] !== 1 || so[k] !== e) begin
        errors++;
        $display("FAIL busy_start L=%0d got pulses=%0d %h want pulses=1 %h", 1 << k, nv[k], so[k], e);
      end
    end
  endtask
  task automatic test_reset_mid();
    int nv [NI];
    sin = rnd_state();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      nv[k] = 0;
      vectors++;
      if (rdy[k] !== 1'b1 || vld[k] !== 1'b0 || so[k] !== '0) begin
        errors++;
        $display("FAIL reset_mid L=%0d got rdy=%b vld=%b so=%h want rdy=1 vld=0 so=0", 1 << k, rdy[k], vld[k], so[k]);
      end
    end
    for (int c = 0; c < 70; c++) begin
      tick();
      for (int k = 0; k < NI; k++) if (vld[k]) nv[k]++;
    end
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (nv[k] !== 0) begin
        errors++;
        $display("FAIL reset_no_valid L=%0d got %0d pulses want 0", 1 << k, nv[k]);
      end
    end
  endtask
  task automatic test_back_to_back();
    type_state pend [NI];
    int last [NI];
    int nv [NI];
    for (int k = 0; k < NI; k++) begin
      last[k] = -1;
      nv[k] = 0;
    end
    sin = rnd_state();
    start = 1'b1;
    for (int k = 0; k < NI; k++) if (rdy[k]) pend[k] = sin;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      for (int k = 0; k < NI; k++)
        if (vld[k]) begin
          vectors++;
          if (so[k] !== model(pend[k], 1'b0)) begin
            errors++;
            $display("FAIL b2b_result L=%0d cyc=%0d got %h want %h", 1 << k, cyc, so[k], model(pend[k], 1'b0));
          end
          if (last[k] >= 0) begin
            vectors++;
            if (cyc - last[k] !== n_of(k) + 1) begin
              errors++;
              $display("FAIL b2b_period L=%0d got %0d want %0d", 1 << k, cyc - last[k], n_of(k) + 1);
            end
          end
          last[k] = cyc;
          nv[k]++;
        end
      sin = rnd_state();
      for (int k = 0; k < NI; k++) if (rdy[k]) pend[k] = sin;
    end
    start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (nv[k] !== 200 / (n_of(k) + 1)) begin
        errors++;
        $display("FAIL b2b_count L=%0d got %0d want %0d", 1 << k, nv[k], 200 / (n_of(k) + 1));
      end
    end
    for (int c = 0; c < 70; c++) tick();
  endtask
`ifdef ASCON_SBOX_INV_EN
  task automatic test_inverse();
    int lat [NI];
    type_state res [NI];
    type_state s, f;
    s = '0;
    s[2] = '1;
    inv = 1'b1;
    run_op(s, lat, res);
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (lat[k] !== n_of(k) + 1 || res[k] !== '0) begin
        errors++;
        $display("FAIL inv_zero L=%0d got lat=%0d %h want lat=%0d 0", 1 << k, lat[k], res[k], n_of(k) + 1);
      end
    end
    for (int t = 0; t < 2; t++) begin
      s = rnd_state();
      f = model(s, 1'b0);
      inv = 1'b0;
      run_op(s, lat, res);
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (res[k] !== f) begin
          errors++;
          $display("FAIL inv_fwd L=%0d got %h want %h", 1 << k, res[k], f);
        end
      end
      inv = 1'b1;
      run_op(f, lat, res);
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (res[k] !== s) begin
          errors++;
          $display("FAIL inv_roundtrip L=%0d got %h want %h", 1 << k, res[k], s);
        end
      end
    end
    inv = 1'b0;
  endtask
`endif
  initial begin
    for (int x = 0; x < 32; x++) sbi[sbf[x]] = 5'(x);
    rst = 1'b1;
    start = 1'b0;
    sin = '0;
`ifdef ASCON_SBOX_INV_EN
    inv = 1'b0;
`endif
    test_reset();
    test_zero();
    test_ones();
    test_random();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
`ifdef ASCON_SBOX_INV_EN
    test_inverse();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
